vga_timing_param: RTL and testbench

//  Parametrised raster timing generator: horizontal/vertical counters, sync, blanking and

---
 rtl/vga_timing_param.sv | 132 +++++++++++++
 tb/tb_vga_timing_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_param.sv
// Parametrised raster timing generator: h/v counters, sync, blanking and line/frame strobes,
// advancing on a pixel-rate enable and followed by an OUT_DELAY-deep aligned output pipeline.
module vga_timing_param #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int COORD_W    = 16,
    parameter int FRAME_W    = 8,
    parameter int OUT_DELAY  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               blank_n,
    output logic               sync_h,
    output logic               sync_v,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYNC_ON  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_OFF = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_ON  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_OFF = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [FRAME_W-1:0] fc;
        logic               blank_n;
        logic               sync_h;
        logic               sync_v;
        logic               line_start;
        logic               frame_start;
    } timing_t;

    localparam timing_t RST_VAL = '{
        x: '0, y: '0, fc: '0, blank_n: 1'b0,
        sync_h: ~H_SYNC_POL, sync_v: ~V_SYNC_POL,
        line_start: 1'b0, frame_start: 1'b0
    };

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [FRAME_W-1:0] frame_idx;
    timing_t            dec;
    timing_t            nxt   [OUT_DELAY+1];
    timing_t            stage [OUT_DELAY+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_idx <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt     <= '0;
                    frame_idx <= frame_idx + FRAME_W'(1);
                end else begin
                    v_cnt <= v_cnt + COORD_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + COORD_W'(1);
            end
        end
    end

    always_comb begin
        dec             = RST_VAL;
        dec.x           = h_cnt;
        dec.y           = v_cnt;
        dec.fc          = frame_idx;
        dec.blank_n     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        dec.sync_h      = ((h_cnt >= H_SYNC_ON) && (h_cnt < H_SYNC_OFF)) ? H_SYNC_POL : ~H_SYNC_POL;
        dec.sync_v      = ((v_cnt >= V_SYNC_ON) && (v_cnt < V_SYNC_OFF)) ? V_SYNC_POL : ~V_SYNC_POL;
        dec.line_start  = (h_cnt == '0);
        dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    always_comb begin
        nxt[0] = dec;
        for (int i = 1; i <= OUT_DELAY; i++) begin
            nxt[i] = stage[i-1];
        end
    end

    // Strobes in the last stage reload every clk so they last one clk, not one pixel period.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= OUT_DELAY; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            if (pix_en) begin
                for (int i = 0; i <= OUT_DELAY; i++) begin
                    stage[i] <= nxt[i];
                end
            end
            stage[OUT_DELAY].line_start  <= pix_en & nxt[OUT_DELAY].line_start;
            stage[OUT_DELAY].frame_start <= pix_en & nxt[OUT_DELAY].frame_start;
        end
    end

    assign pos_x       = stage[OUT_DELAY].x;
    assign pos_y       = stage[OUT_DELAY].y;
    assign frame_count = stage[OUT_DELAY].fc;
    assign blank_n     = stage[OUT_DELAY].blank_n;
    assign sync_h      = stage[OUT_DELAY].sync_h;
    assign sync_v      = stage[OUT_DELAY].sync_v;
    assign line_start  = stage[OUT_DELAY].line_start;
    assign frame_start = stage[OUT_DELAY].frame_start;

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: a small mode (OUT_DELAY=3, FRAME_W=2) and the default mode
// (OUT_DELAY=0, negative syncs) checked every clk against a queue-based latency model.
module tb_vga_timing_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] s_x, s_y, d_x, d_y;
    logic [1:0]  s_fc;
    logic [7:0]  d_fc;
    logic        s_bl, s_sh, s_sv, s_ls, s_fs;
    logic        d_bl, d_sh, d_sv, d_ls, d_fs;

    vga_timing_param #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0),
        .COORD_W(16), .FRAME_W(2), .OUT_DELAY(3)
    ) dut_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .pos_x(s_x), .pos_y(s_y), .blank_n(s_bl), .sync_h(s_sh), .sync_v(s_sv),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_timing_param #(
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .OUT_DELAY(0)
    ) dut_std (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .pos_x(d_x), .pos_y(d_y), .blank_n(d_bl), .sync_h(d_sh), .sync_v(d_sv),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int hpol, vpol, fw, od;
    } mode_t;

    mode_t       md [2];
    int          mh [2];
    int          mv [2];
    int          mf [2];
    logic [44:0] held [2];
    logic [44:0] expv [2];
    logic [44:0] q0 [$];
    logic [44:0] q1 [$];

    int n_checks = 0;
    int n_fail   = 0;
    bit stat_on  = 1'b0;
    int c_ls = 0, c_fs = 0, c_shl = 0, c_dbl = 0, c_sbl = 0, c_sfs = 0;

    function automatic logic [44:0] pack(input logic [15:0] x, input logic [15:0] y,
                                         input logic [7:0] fc, input logic bl, input logic sh,
                                         input logic sv, input logic ls, input logic fs);
        return {x, y, fc, bl, sh, sv, ls, fs};
    endfunction

    wire [44:0] obs0 = pack(s_x, s_y, {6'b0, s_fc}, s_bl, s_sh, s_sv, s_ls, s_fs);
    wire [44:0] obs1 = pack(d_x, d_y, d_fc, d_bl, d_sh, d_sv, d_ls, d_fs);

    function automatic logic [44:0] decode(input mode_t m, input int h, input int v, input int f);
        int   hs0, vs0;
        logic sh, sv;
        logic [7:0] fc;
        hs0 = m.ha + m.hfp;
        vs0 = m.va + m.vfp;
        sh  = (h >= hs0 && h < hs0 + m.hs) ? (m.hpol != 0) : (m.hpol == 0);
        sv  = (v >= vs0 && v < vs0 + m.vs) ? (m.vpol != 0) : (m.vpol == 0);
        fc  = 8'(f % (1 << m.fw));
        return pack(16'(h), 16'(v), fc, (h < m.ha) && (v < m.va), sh, sv, h == 0, h == 0 && v == 0);
    endfunction

    function automatic logic [44:0] rst_tuple(input mode_t m);
        return pack(16'd0, 16'd0, 8'd0, 1'b0, m.hpol == 0, m.vpol == 0, 1'b0, 1'b0);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model of one clk edge: expected tuples are queued on enabled edges and leave the
    // queue once 1+OUT_DELAY enabled edges have passed.
    task automatic model_step(input int i);
        logic [44:0] t;
        int ht, vt;
        ht = md[i].ha + md[i].hfp + md[i].hs + md[i].hbp;
        vt = md[i].va + md[i].vfp + md[i].vs + md[i].vbp;
        if (rst) begin
            mh[i] = 0; mv[i] = 0; mf[i] = 0;
            held[i] = rst_tuple(md[i]);
            if (i == 0) q0.delete(); else q1.delete();
        end else if (pix_en) begin
            t = decode(md[i], mh[i], mv[i], mf[i]);
            if (i == 0) q0.push_back(t); else q1.push_back(t);
            mh[i]++;
            if (mh[i] == ht) begin
                mh[i] = 0;
                mv[i]++;
                if (mv[i] == vt) begin
                    mv[i] = 0;
                    mf[i]++;
                end
            end
            if (i == 0) begin
                if (q0.size() > md[0].od) held[0] = q0.pop_front();
            end else begin
                if (q1.size() > md[1].od) held[1] = q1.pop_front();
            end
        end
        expv[i] = (!rst && pix_en) ? held[i] : {held[i][44:2], 2'b00};
    endtask

    task automatic tick(input logic r, input logic e);
        rst    = r;
        pix_en = e;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_eq("small", 64'(obs0), 64'(expv[0]));
        check_eq("std", 64'(obs1), 64'(expv[1]));
        if (stat_on) begin
            if (d_ls) c_ls++;
            if (d_fs) c_fs++;
            if (d_bl) c_dbl++;
            if (d_y == 16'd0 && !d_sh) c_shl++;
            if (s_bl) c_sbl++;
            if (s_fs) c_sfs++;
        end
    endtask

    initial begin
        md[0] = '{ha: 4, hfp: 1, hs: 2, hbp: 1, va: 3, vfp: 0, vs: 1, vbp: 1,
                  hpol: 1, vpol: 0, fw: 2, od: 3};
        md[1] = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33,
                  hpol: 0, vpol: 0, fw: 8, od: 0};

        for (int k = 0; k < 5; k++) tick(1'b1, 1'b1);
        check_eq("rst_small", 64'(obs0), 64'(pack(16'd0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
        check_eq("rst_std", 64'(obs1), 64'(pack(16'd0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)));

        stat_on = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            tick(1'b0, 1'b1);
            if (k == 1) check_eq("lat_std", 64'(d_fs), 64'd1);
            if (k == 3) check_eq("lat_small_pre", 64'(s_fs), 64'd0);
            if (k == 4) check_eq("lat_small", 64'(s_fs), 64'd1);
        end
        stat_on = 1'b0;
        check_eq("std_line_starts", 64'(c_ls), 64'd4);
        check_eq("std_frame_starts", 64'(c_fs), 64'd1);
        check_eq("std_sync_h_width", 64'(c_shl), 64'd96);
        check_eq("std_active_pixels", 64'(c_dbl), 64'd2520);
        check_eq("small_active_pixels", 64'(c_sbl), 64'd900);
        check_eq("small_frame_starts", 64'(c_sfs), 64'd75);

        for (int k = 0; k < 2000; k++) tick(1'b0, (k % 4) == 3);
        for (int k = 0; k < 2000; k++) tick(1'b0, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
        for (int k = 0; k < 1000; k++) tick(1'b0, 1'b1);
        for (int k = 0; k < 500; k++) tick(1'b0, 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
